dds_dac_driver: RTL and testbench
=================================

# dds_dac_driver

Output stage directly downstream of the DDS phase-accumulator/ROM block. It takes the four 8-bit waveform samples, selects one, applies a 4-bit amplitude scale, and serialises the result as a 16-bit frame to an external serial DAC over a 3-wire SPI-style link (CS_N, SCLK, DIN). It runs continuously while enabled and captures a fresh sample at the start of every frame.

## Interface
- CLK_DIV, 4: clk cycles per SCLK half-period; legal range 1..255.
- CTRL_BITS, 4'b0000: 4 control bits sent ahead of the data byte in each frame.

- clk  input  1  system clock, shared with the DDS block.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  run enable; sampled in IDLE only.
- wave_sel  input  2  source select: 0 sine, 1 square, 2 triangle, 3 sawtooth.
- amp  input  4  amplitude code; gain = (amp+1)/16.
- sine_wave  input  8  sine sample, unsigned.
- square_wave  input  8  square sample, unsigned.
- triangle_wave  input  8  triangle sample, unsigned.
- sawtooth_wave  input  8  sawtooth sample, unsigned.
- dac_cs_n  output  1  DAC chip select, active low.
- dac_sclk  output  1  DAC serial clock.
- dac_din  output  1  DAC serial data, MSB first.
- busy  output  1  high while a frame is in progress (LOAD, SHIFT, GAP).
- frame_done  output  1  one-cycle pulse on the last GAP cycle.
- sample_out  output  8  scaled sample of the current or most recent frame.

## Operation
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE: cs_n=1, sclk=0, din=0, busy=0. If en=1, go to LOAD on the next edge; otherwise stay.
- LOAD (1 cycle): mux the selected wave and compute scaled = (wave × (amp+1)) >> 4.
  - The product is 12 bits and scaled is product[11:4], so no overflow is possible.
  - amp=15 is identity. amp=0 gives wave>>4.
  - Register scaled into sample_out.
  - Build frame = {CTRL_BITS, scaled, 4'b0000}, 16 bits.
  - Drive cs_n=0 and din=frame[15]. Bit counter = 15. Go to SHIFT.
- SHIFT: each bit occupies 2×CLK_DIV cycles.
  - sclk is low for the first CLK_DIV cycles and high for the second CLK_DIV cycles.
  - On each sclk falling edge (high→low), din advances to the next lower frame bit.
  - After the high phase of bit 0 completes, sclk returns to 0 and the FSM goes to GAP.
  - din holds stable for the full high phase. The DAC samples on the sclk rising edge.
- GAP (CLK_DIV cycles): cs_n=1, sclk=0, din=0. frame_done=1 on the final GAP cycle. Then go to IDLE.
- Inputs are captured only in LOAD. wave_sel, amp and wave changes during SHIFT or GAP do not affect the frame in flight.
- Dropping en mid-frame does not abort: the frame completes, and the FSM then stays in IDLE.
- sample_out holds its value until the next LOAD.
- Reset (asynchronous, any state) immediately forces:
  - state=IDLE;
  - cs_n=1, sclk=0, din=0, busy=0, frame_done=0;
  - sample_out=8'h00, bit counter=0, divider counter=0.
  - A partial frame is abandoned; the DAC discards it because cs_n rises before 16 clocks.

## Timing
- All outputs are registered; none is combinational from inputs.
- Reset values: dac_cs_n=1, dac_sclk=0, dac_din=0, busy=0, frame_done=0, sample_out=0.
- en=1 seen in IDLE leads to LOAD on the next cycle. cs_n falls and sample_out updates at the end of the LOAD cycle.
- Frame length: 1 (LOAD) + 32×CLK_DIV (SHIFT) + CLK_DIV (GAP) cycles, then 1 IDLE cycle.
  - Continuous-run period = 33×CLK_DIV + 2 cycles.
  - CLK_DIV=4 gives 134 cycles.
- The first sclk rising edge occurs CLK_DIV cycles after cs_n falls. Exactly 16 sclk rising edges occur per completed frame.
- frame_done goes high in the same cycle as the last GAP cycle, before IDLE.
- busy=1 from the first LOAD cycle through the last GAP cycle inclusive.

## Test plan
- Reset, then hold rst_n=0 for 5 cycles: outputs stay at reset values. Release with en=0: cs_n stays 1 and sclk stays 0 for 200 cycles.
- CLK_DIV=4, en=1, wave_sel=0, sine_wave=8'hA5, amp=15 → sample_out=8'hA5. With CTRL_BITS=0, the 16 bits captured on sclk rising edges are 16'h0A50. 16 rising edges occur, frame_done pulses once, and the period is 134 cycles.
- wave_sel=3, sawtooth_wave=8'hFF, amp=0 → sample_out=8'h0F. wave_sel=1, square_wave=8'hFF, amp=7 → sample_out=8'h7F.
- Change wave_sel and amp 20 cycles into SHIFT → the current frame is unchanged and the new values appear in the next frame.
- Deassert en during SHIFT of frame N → frame N completes with 16 sclk edges and frame_done. No frame N+1 starts. busy=0 and cs_n=1 thereafter.
- Assert rst_n=0 mid-SHIFT, after bit 9 → cs_n, sclk, din and busy go to reset values asynchronously, before the next clk edge. After release with en=1, a complete fresh frame is sent.

Source files
------------

// File: rtl/dds_dac_driver_if.sv
// -----------------------------------------------------------------------------
// dds_dac_driver_if
// Bundles the run control, the four DDS waveform samples, the serial DAC link
// and the frame status of dds_dac_driver.
//   master : the driver side. It takes control and samples in, and drives the
//            DAC link and status out.
//   slave  : the upstream controller / DDS side. It drives control and samples,
//            and observes the DAC link and status.
// Signals:
//   en, wave_sel[1:0], amp[3:0]       run enable, source select, amplitude code
//   sine/square/triangle/sawtooth_wave[7:0]  unsigned waveform samples
//   dac_cs_n, dac_sclk, dac_din        3-wire serial DAC link
//   busy, frame_done, sample_out[7:0]  frame status and last scaled sample
// -----------------------------------------------------------------------------
interface dds_dac_driver_if;
    logic       en;
    logic [1:0] wave_sel;
    logic [3:0] amp;
    logic [7:0] sine_wave;
    logic [7:0] square_wave;
    logic [7:0] triangle_wave;
    logic [7:0] sawtooth_wave;
    logic       dac_cs_n;
    logic       dac_sclk;
    logic       dac_din;
    logic       busy;
    logic       frame_done;
    logic [7:0] sample_out;

    modport master (
        input  en, wave_sel, amp,
        input  sine_wave, square_wave, triangle_wave, sawtooth_wave,
        output dac_cs_n, dac_sclk, dac_din,
        output busy, frame_done, sample_out
    );

    modport slave (
        output en, wave_sel, amp,
        output sine_wave, square_wave, triangle_wave, sawtooth_wave,
        input  dac_cs_n, dac_sclk, dac_din,
        input  busy, frame_done, sample_out
    );
endinterface

// File: rtl/dds_dac_driver.sv
// -----------------------------------------------------------------------------
// dds_dac_driver
// Output stage behind the DDS block. At the start of every frame it selects one
// of four 8-bit waveform samples, scales it by (amp+1)/16 and sends the frame
// {CTRL_BITS, scaled, 4'b0000} MSB first to a serial DAC. SCLK is low for the
// first CLK_DIV cycles of each bit and high for the second CLK_DIV cycles; the
// DAC samples DIN on the SCLK rising edge.
// Ports:
//   clk    system clock (shared with the DDS block)
//   rst_n  asynchronous active-low reset
//   bus    dds_dac_driver_if.master: control/sample inputs, DAC link, status
// Parameters:
//   CLK_DIV    clk cycles per SCLK half-period, 1..255
//   CTRL_BITS  4 control bits sent ahead of the data byte
// -----------------------------------------------------------------------------
module dds_dac_driver #(
    parameter int         CLK_DIV   = 4,
    parameter logic [3:0] CTRL_BITS = 4'b0000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dds_dac_driver_if.master       bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    // Divider count values: last cycle of the low phase (also last GAP cycle),
    // last cycle of a whole bit, and the GAP cycle just before the final one.
    localparam logic [8:0] HALF_END = 9'(CLK_DIV - 1);
    localparam logic [8:0] FULL_END = 9'(2 * CLK_DIV - 1);
    localparam logic [8:0] GAP_PRE  = 9'(CLK_DIV - 2);

    state_t      state_r;
    logic [8:0]  div_cnt_r;
    logic [3:0]  bit_cnt_r;
    logic [14:0] frame_r;      // remaining lower frame bits, next bit at [14]
    logic        cs_n_r;
    logic        sclk_r;
    logic        din_r;
    logic        busy_r;
    logic        frame_done_r;
    logic [7:0]  sample_r;

    logic [7:0]  wave_s;
    logic [4:0]  amp_p1_s;
    logic [11:0] prod_s;
    logic [15:0] frame_s;

    // Select the requested waveform sample and form the scaled frame word.
    always_comb begin
        wave_s = 8'h00;
        case (bus.wave_sel)
            2'd0:    wave_s = bus.sine_wave;
            2'd1:    wave_s = bus.square_wave;
            2'd2:    wave_s = bus.triangle_wave;
            2'd3:    wave_s = bus.sawtooth_wave;
            default: wave_s = 8'h00;
        endcase
        // 255 * 16 = 4080 fits in 12 bits, so the product never wraps.
        amp_p1_s = {1'b0, bus.amp} + 5'd1;
        prod_s   = {4'b0000, wave_s} * {7'b0000000, amp_p1_s};
        // Clearing the low nibble keeps prod_s[11:4] as the data byte and
        // provides the four trailing zero bits of the frame.
        frame_s  = {CTRL_BITS, prod_s} & 16'hFFF0;
    end

    // Frame sequencer: all DAC link and status outputs are registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            div_cnt_r    <= 9'd0;
            bit_cnt_r    <= 4'd0;
            frame_r      <= 15'd0;
            cs_n_r       <= 1'b1;
            sclk_r       <= 1'b0;
            din_r        <= 1'b0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            sample_r     <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cs_n_r       <= 1'b1;
                    sclk_r       <= 1'b0;
                    din_r        <= 1'b0;
                    frame_done_r <= 1'b0;
                    div_cnt_r    <= 9'd0;
                    if (bus.en) begin
                        state_r <= ST_LOAD;
                        busy_r  <= 1'b1;
                    end else begin
                        busy_r  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    sample_r  <= frame_s[11:4];
                    frame_r   <= frame_s[14:0];
                    din_r     <= frame_s[15];
                    cs_n_r    <= 1'b0;
                    sclk_r    <= 1'b0;
                    bit_cnt_r <= 4'd15;
                    div_cnt_r <= 9'd0;
                    state_r   <= ST_SHIFT;
                end
                ST_SHIFT: begin
                    if (div_cnt_r == FULL_END) begin
                        // End of a bit: SCLK falls and DIN moves to the next bit.
                        div_cnt_r <= 9'd0;
                        sclk_r    <= 1'b0;
                        if (bit_cnt_r == 4'd0) begin
                            state_r      <= ST_GAP;
                            cs_n_r       <= 1'b1;
                            din_r        <= 1'b0;
                            // With a one-cycle gap the first GAP cycle is the last.
                            frame_done_r <= (HALF_END == 9'd0);
                        end else begin
                            bit_cnt_r <= bit_cnt_r - 4'd1;
                            din_r     <= frame_r[14];
                            frame_r   <= {frame_r[13:0], 1'b0};
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + 9'd1;
                        if (div_cnt_r == HALF_END) begin
                            sclk_r <= 1'b1;
                        end else begin
                            sclk_r <= sclk_r;
                        end
                    end
                end
                ST_GAP: begin
                    if (div_cnt_r == HALF_END) begin
                        state_r      <= ST_IDLE;
                        busy_r       <= 1'b0;
                        frame_done_r <= 1'b0;
                        div_cnt_r    <= 9'd0;
                    end else begin
                        div_cnt_r    <= div_cnt_r + 9'd1;
                        frame_done_r <= (div_cnt_r == GAP_PRE);
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    div_cnt_r    <= 9'd0;
                    bit_cnt_r    <= 4'd0;
                    cs_n_r       <= 1'b1;
                    sclk_r       <= 1'b0;
                    din_r        <= 1'b0;
                    busy_r       <= 1'b0;
                    frame_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.dac_cs_n   = cs_n_r;
    assign bus.dac_sclk   = sclk_r;
    assign bus.dac_din    = din_r;
    assign bus.busy       = busy_r;
    assign bus.frame_done = frame_done_r;
    assign bus.sample_out = sample_r;

endmodule

// File: tb/tb_dds_dac_driver.sv
// -----------------------------------------------------------------------------
// tb_dds_dac_driver
// Directed stimulus pushes the hand-computed frame/sample of every frame it
// starts into a scoreboard queue; an independent monitor deserialises DIN on
// SCLK rising edges and pops/compares on each frame_done pulse.
// -----------------------------------------------------------------------------
module tb_dds_dac_driver;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    dds_dac_driver_if bus_if ();

    dds_dac_driver #(
        .CLK_DIV   (4),
        .CTRL_BITS (4'b0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] frame;
        logic [7:0]  sample;
    } exp_t;

    exp_t exp_q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;
    int   n_pushed     = 0;
    int   cyc          = 0;

    // Monitor state
    int          edges       = 0;
    int          n_starts    = 0;
    int          done_cycles = 0;
    int          last_fall   = 0;
    int          prev_fall   = 0;
    int          busy_cnt    = 0;
    int          busy_len    = 0;
    logic [15:0] shreg       = 16'h0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic push(input logic [15:0] frame, input logic [7:0] sample);
        exp_q.push_back({frame, sample});
        n_pushed++;
    endtask

    task automatic wait_busy(input logic v, input int bound, input string name);
        int n = 0;
        while (bus_if.busy !== v && n < bound) begin
            @(negedge clk);
            n++;
        end
        if (bus_if.busy !== v) check(name, {31'd0, bus_if.busy}, {31'd0, v});
    endtask

    // Monitor: deserialise the DAC link and score each completed frame.
    initial begin : monitor
        logic prev_sclk;
        logic prev_cs_n;
        logic prev_busy;
        exp_t e;
        prev_sclk = 1'b0;
        prev_cs_n = 1'b1;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_cs_n && !bus_if.dac_cs_n) begin
                n_starts++;
                prev_fall = last_fall;
                last_fall = cyc;
                edges     = 0;
                shreg     = 16'h0000;
            end
            if (!prev_sclk && bus_if.dac_sclk && !bus_if.dac_cs_n) begin
                edges++;
                shreg = {shreg[14:0], bus_if.dac_din};
            end
            if (bus_if.busy) begin
                busy_cnt++;
            end else if (prev_busy) begin
                busy_len = busy_cnt;
                busy_cnt = 0;
            end
            if (bus_if.frame_done) begin
                done_cycles++;
                if (exp_q.size() == 0) begin
                    check("unexpected_frame", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_bits", {16'd0, shreg}, {16'd0, e.frame});
                    check("sclk_edges", edges, 32'd16);
                    check("sample_out", {24'd0, bus_if.sample_out}, {24'd0, e.sample});
                end
            end
            prev_sclk = bus_if.dac_sclk;
            prev_cs_n = bus_if.dac_cs_n;
            prev_busy = bus_if.busy;
        end
    end

    // Directed stimulus.
    initial begin : stimulus
        int bad;
        int starts;
        int n;
        bus_if.en            = 1'b0;
        bus_if.wave_sel      = 2'd0;
        bus_if.amp           = 4'd0;
        bus_if.sine_wave     = 8'h00;
        bus_if.square_wave   = 8'h00;
        bus_if.triangle_wave = 8'h00;
        bus_if.sawtooth_wave = 8'h00;

        // Reset held for 5 cycles
        repeat (5) @(negedge clk);
        check("rst_cs_n",   {31'd0, bus_if.dac_cs_n},   32'd1);
        check("rst_sclk",   {31'd0, bus_if.dac_sclk},   32'd0);
        check("rst_din",    {31'd0, bus_if.dac_din},    32'd0);
        check("rst_busy",   {31'd0, bus_if.busy},       32'd0);
        check("rst_done",   {31'd0, bus_if.frame_done}, 32'd0);
        check("rst_sample", {24'd0, bus_if.sample_out}, 32'd0);

        // Released with en=0: link stays idle
        rst_n = 1'b1;
        bad = 0;
        repeat (200) begin
            @(negedge clk);
            if (bus_if.dac_cs_n !== 1'b1 || bus_if.dac_sclk !== 1'b0) bad++;
        end
        check("idle_en0", bad, 32'd0);

        // Two back-to-back sine frames, amp=15 (identity)
        bus_if.wave_sel  = 2'd0;
        bus_if.sine_wave = 8'hA5;
        bus_if.amp       = 4'd15;
        bus_if.en        = 1'b1;
        push(16'h0A50, 8'hA5);
        wait_busy(1'b1, 10, "start_sine1");
        push(16'h0A50, 8'hA5);
        wait_busy(1'b0, 200, "end_sine1");
        check("busy_len", busy_len, 32'd133);
        wait_busy(1'b1, 10, "start_sine2");
        bus_if.en = 1'b0;
        wait_busy(1'b0, 200, "end_sine2");
        check("period", last_fall - prev_fall, 32'd134);

        // Sawtooth FF with amp=0 -> FF>>4
        bus_if.wave_sel      = 2'd3;
        bus_if.sawtooth_wave = 8'hFF;
        bus_if.amp           = 4'd0;
        bus_if.en            = 1'b1;
        push(16'h00F0, 8'h0F);
        wait_busy(1'b1, 10, "start_saw");
        bus_if.en = 1'b0;
        wait_busy(1'b0, 200, "end_saw");

        // Square FF with amp=7 -> FF*8>>4 = 7F
        bus_if.wave_sel    = 2'd1;
        bus_if.square_wave = 8'hFF;
        bus_if.amp         = 4'd7;
        bus_if.en          = 1'b1;
        push(16'h07F0, 8'h7F);
        wait_busy(1'b1, 10, "start_sq");
        bus_if.en = 1'b0;
        wait_busy(1'b0, 200, "end_sq");

        // Inputs change 20 cycles into SHIFT: next frame only
        bus_if.wave_sel      = 2'd0;
        bus_if.sine_wave     = 8'h80;
        bus_if.triangle_wave = 8'h64;
        bus_if.amp           = 4'd15;
        bus_if.en            = 1'b1;
        push(16'h0800, 8'h80);
        wait_busy(1'b1, 10, "start_chg1");
        repeat (21) @(negedge clk);
        bus_if.wave_sel  = 2'd2;
        bus_if.amp       = 4'd3;
        bus_if.sine_wave = 8'h11;
        push(16'h0190, 8'h19);    // 0x64 * 4 = 400, >>4 = 25
        wait_busy(1'b0, 200, "end_chg1");
        wait_busy(1'b1, 10, "start_chg2");
        bus_if.en = 1'b0;
        wait_busy(1'b0, 200, "end_chg2");

        // en dropped during SHIFT: frame completes, nothing follows
        bus_if.wave_sel      = 2'd3;
        bus_if.sawtooth_wave = 8'h40;
        bus_if.amp           = 4'd15;
        bus_if.en            = 1'b1;
        push(16'h0400, 8'h40);
        wait_busy(1'b1, 10, "start_endrop");
        repeat (30) @(negedge clk);
        bus_if.en = 1'b0;
        starts = n_starts;
        wait_busy(1'b0, 200, "end_endrop");
        repeat (300) @(negedge clk);
        check("no_next_frame", n_starts - starts, 32'd0);
        check("endrop_busy", {31'd0, bus_if.busy},     32'd0);
        check("endrop_cs_n", {31'd0, bus_if.dac_cs_n}, 32'd1);

        // Asynchronous reset mid-SHIFT, then a fresh frame
        bus_if.wave_sel  = 2'd0;
        bus_if.sine_wave = 8'h3C;
        bus_if.amp       = 4'd15;
        bus_if.en        = 1'b1;
        wait_busy(1'b1, 10, "start_abort");
        n = 0;
        while (edges < 10 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_bit9", {31'd0, (edges >= 10)}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_cs_n",   {31'd0, bus_if.dac_cs_n},   32'd1);
        check("async_sclk",   {31'd0, bus_if.dac_sclk},   32'd0);
        check("async_din",    {31'd0, bus_if.dac_din},    32'd0);
        check("async_busy",   {31'd0, bus_if.busy},       32'd0);
        check("async_sample", {24'd0, bus_if.sample_out}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(16'h03C0, 8'h3C);
        wait_busy(1'b1, 10, "start_fresh");
        bus_if.en = 1'b0;
        wait_busy(1'b0, 200, "end_fresh");
        repeat (5) @(negedge clk);

        check("queue_empty", exp_q.size(), 32'd0);
        check("done_pulses", done_cycles, n_pushed);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
